// File: rtl/control_decode.sv
// Instruction decoder for the single-cycle LEGv8 CPU: opcode -> datapath strobes and
// ALU op, D-type offset -> magnitude/sign, plus a sticky illegal-opcode flag.
module control_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic [8:0]  dAddr9,
  output logic        uncondBr,
  output logic        branch,
  output logic        branchReg,
  output logic        branchLink,
  output logic        Reg2Loc,
  output logic        ALU_Src,
  output logic        Imm,
  output logic        RegWrite,
  output logic        memToReg,
  output logic        memWrite,
  output logic        memRead,
  output logic        ALU_SH,
  output logic        shiftDirn,
  output logic        ALU_on,
  output logic        set_flags,
  output logic [2:0]  ALU_cntrl,
  output logic [63:0] offset,
  output logic        offset_neg,
  output logic        illegal
);

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;

  typedef struct packed {
    logic uncond_br;
    logic branch;
    logic branch_reg;
    logic branch_link;
    logic reg2loc;
    logic alu_src;
    logic imm;
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic alu_sh;
    logic shift_dirn;
    logic alu_on;
    logic set_flags;
  } ctrl_t;

  ctrl_t       dec;
  logic [2:0]  dec_cntrl;
  logic        known;
  ctrl_t       ctrl;
  logic [2:0]  ctrl_cntrl;
  logic        mem_sub;
  logic signed [63:0] sext;
  logic        illegal_d;
  logic        illegal_q;

  // Ripple-free behavioural add/subtract: in1 + (sub ? ~in2 : in2) + sub.
  function automatic logic [63:0] add_sub(input logic [63:0] in1,
                                          input logic [63:0] in2,
                                          input logic        sub);
    logic [63:0] b;
    b = sub ? ~in2 : in2;
    return in1 + b + {63'd0, sub};
  endfunction

  assign mem_sub = dAddr9[8];

  // Exact 11-bit matches take priority, then progressively shorter opcode prefixes.
  always_comb begin
    dec       = '0;
    dec_cntrl = ALU_PASS;
    known     = 1'b1;
    case (opcode)
      11'b10101011000: begin  // ADDS
        dec.reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_on    = 1'b1;
        dec.set_flags = 1'b1;
        dec_cntrl     = ALU_ADD;
      end
      11'b11101011000: begin  // SUBS
        dec.reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_on    = 1'b1;
        dec.set_flags = 1'b1;
        dec_cntrl     = ALU_SUB;
      end
      11'b11111000010: begin  // LDUR
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_on     = 1'b1;
        dec_cntrl      = mem_sub ? ALU_SUB : ALU_ADD;
      end
      11'b11111000000: begin  // STUR
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_on    = 1'b1;
        dec_cntrl     = mem_sub ? ALU_SUB : ALU_ADD;
      end
      11'b11010011011: begin  // LSL
        dec.reg_write = 1'b1;
        dec.alu_sh    = 1'b1;
      end
      11'b11010011010: begin  // LSR
        dec.reg_write  = 1'b1;
        dec.alu_sh     = 1'b1;
        dec.shift_dirn = 1'b1;
      end
      11'b11010110000: begin  // BR
        dec.branch     = 1'b1;
        dec.uncond_br  = 1'b1;
        dec.branch_reg = 1'b1;
      end
      default: begin
        case (opcode[10:1])
          10'b1001000100: begin  // ADDI
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm       = 1'b1;
            dec.alu_on    = 1'b1;
            dec_cntrl     = ALU_ADD;
          end
          default: begin
            case (opcode[10:3])
              8'b10110100: begin  // CBZ: ALU passes the register through for the zero test
                dec.branch = 1'b1;
                dec.alu_on = 1'b1;
                dec_cntrl  = ALU_PASS;
              end
              8'b01010100: begin  // B.cond
                dec.branch = 1'b1;
              end
              default: begin
                case (opcode[10:5])
                  6'b000101: begin  // B
                    dec.branch    = 1'b1;
                    dec.uncond_br = 1'b1;
                  end
                  6'b100101: begin  // BL
                    dec.branch      = 1'b1;
                    dec.uncond_br   = 1'b1;
                    dec.branch_link = 1'b1;
                    dec.reg_write   = 1'b1;
                  end
                  default: known = 1'b0;
                endcase
              end
            endcase
          end
        endcase
      end
    endcase
  end

  // Reset gates every strobe so nothing is written while the CPU is held in reset.
  always_comb begin
    ctrl       = rst ? '0 : dec;
    ctrl_cntrl = rst ? ALU_PASS : dec_cntrl;
  end

  assign uncondBr   = ctrl.uncond_br;
  assign branch     = ctrl.branch;
  assign branchReg  = ctrl.branch_reg;
  assign branchLink = ctrl.branch_link;
  assign Reg2Loc    = ctrl.reg2loc;
  assign ALU_Src    = ctrl.alu_src;
  assign Imm        = ctrl.imm;
  assign RegWrite   = ctrl.reg_write;
  assign memToReg   = ctrl.mem_to_reg;
  assign memWrite   = ctrl.mem_write;
  assign memRead    = ctrl.mem_read;
  assign ALU_SH     = ctrl.alu_sh;
  assign shiftDirn  = ctrl.shift_dirn;
  assign ALU_on     = ctrl.alu_on;
  assign set_flags  = ctrl.set_flags;
  assign ALU_cntrl  = ctrl_cntrl;

  // Negative offsets are negated as 0 - s; -256 becomes +256, which fits easily in 64 bits.
  assign sext       = {{55{dAddr9[8]}}, dAddr9};
  assign offset     = add_sub(64'd0, sext, dAddr9[8]);
  assign offset_neg = dAddr9[8];

  always_comb begin
    illegal_d = illegal_q;
    if (rst)
      illegal_d = 1'b0;
    else if (!known)
      illegal_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_decode.sv
// Bench for control_decode: directed vector table, sticky-flag sequence and randomized
// opcodes checked against a pattern-match reference model.
module tb_control_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode;
  logic [8:0]  dAddr9;
  logic uncondBr, branch, branchReg, branchLink, Reg2Loc, ALU_Src, Imm, RegWrite;
  logic memToReg, memWrite, memRead, ALU_SH, shiftDirn, ALU_on, set_flags;
  logic [2:0]  ALU_cntrl;
  logic [63:0] offset;
  logic        offset_neg;
  logic        illegal;

  always #5 clk = ~clk;

  control_decode dut (
    .clk(clk), .rst(rst), .opcode(opcode), .dAddr9(dAddr9),
    .uncondBr(uncondBr), .branch(branch), .branchReg(branchReg), .branchLink(branchLink),
    .Reg2Loc(Reg2Loc), .ALU_Src(ALU_Src), .Imm(Imm), .RegWrite(RegWrite),
    .memToReg(memToReg), .memWrite(memWrite), .memRead(memRead), .ALU_SH(ALU_SH),
    .shiftDirn(shiftDirn), .ALU_on(ALU_on), .set_flags(set_flags), .ALU_cntrl(ALU_cntrl),
    .offset(offset), .offset_neg(offset_neg), .illegal(illegal)
  );

  // Strobe vector order: ub br brg bl | r2l src imm rw | m2r mw mr sh | dir on sf
  typedef struct packed {
    logic ub, br, brg, bl, r2l, src, imm, rw, m2r, mw, mr, sh, dir, on, sf;
  } ctl_t;

  typedef struct packed {
    logic       known;
    ctl_t       c;
    logic [2:0] cn;
  } model_t;

  typedef struct {
    string       name;
    logic [10:0] op;
    logic [8:0]  d;
    logic        r;
    ctl_t        ec;
    logic [2:0]  ecn;
    logic [63:0] eo;
    logic        en;
  } vec_t;

  ctl_t act;
  assign act = {uncondBr, branch, branchReg, branchLink, Reg2Loc, ALU_Src, Imm, RegWrite,
                memToReg, memWrite, memRead, ALU_SH, shiftDirn, ALU_on, set_flags};

  int   checks   = 0;
  int   failures = 0;
  logic model_ill;

  function automatic model_t ref_model(input logic [10:0] op, input logic [8:0] d,
                                       input logic r);
    model_t m;
    m = '0;
    m.known = 1'b1;
    if (op == 11'b10101011000) begin
      m.c.r2l = 1; m.c.rw = 1; m.c.on = 1; m.c.sf = 1; m.cn = 3'b010;
    end else if (op == 11'b11101011000) begin
      m.c.r2l = 1; m.c.rw = 1; m.c.on = 1; m.c.sf = 1; m.cn = 3'b011;
    end else if (op == 11'b11111000010) begin
      m.c.src = 1; m.c.rw = 1; m.c.m2r = 1; m.c.mr = 1; m.c.on = 1;
      m.cn = d[8] ? 3'b011 : 3'b010;
    end else if (op == 11'b11111000000) begin
      m.c.src = 1; m.c.mw = 1; m.c.on = 1;
      m.cn = d[8] ? 3'b011 : 3'b010;
    end else if (op == 11'b11010011011) begin
      m.c.rw = 1; m.c.sh = 1;
    end else if (op == 11'b11010011010) begin
      m.c.rw = 1; m.c.sh = 1; m.c.dir = 1;
    end else if (op == 11'b11010110000) begin
      m.c.br = 1; m.c.ub = 1; m.c.brg = 1;
    end else if (op ==? 11'b1001000100?) begin
      m.c.rw = 1; m.c.src = 1; m.c.imm = 1; m.c.on = 1; m.cn = 3'b010;
    end else if (op ==? 11'b10110100???) begin
      m.c.br = 1; m.c.on = 1;
    end else if (op ==? 11'b01010100???) begin
      m.c.br = 1;
    end else if (op ==? 11'b000101?????) begin
      m.c.br = 1; m.c.ub = 1;
    end else if (op ==? 11'b100101?????) begin
      m.c.br = 1; m.c.ub = 1; m.c.bl = 1; m.c.rw = 1;
    end else begin
      m.known = 1'b0;
    end
    if (r) begin
      m.c  = '0;
      m.cn = 3'b000;
    end
    return m;
  endfunction

  function automatic logic [63:0] ref_offset(input logic [8:0] d);
    int v;
    v = int'(d);
    if (d[8]) v = 512 - v;
    return 64'(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  // Drive away from the active edge, check after settling; illegal is updated at the next posedge.
  task automatic step(input vec_t v);
    model_t m;
    @(negedge clk);
    opcode = v.op;
    dAddr9 = v.d;
    rst    = v.r;
    #1;
    chk({v.name, ".ctrl"},    64'(act),        64'(v.ec));
    chk({v.name, ".cntrl"},   64'(ALU_cntrl),  64'(v.ecn));
    chk({v.name, ".offset"},  offset,          v.eo);
    chk({v.name, ".neg"},     64'(offset_neg), 64'(v.en));
    chk({v.name, ".illegal"}, 64'(illegal),    64'(model_ill));
    m = ref_model(v.op, v.d, v.r);
    if (v.r)           model_ill = 1'b0;
    else if (!m.known) model_ill = 1'b1;
  endtask

  function automatic vec_t mk(input string nm, input logic [10:0] op, input logic [8:0] d,
                              input logic r, input ctl_t ec, input logic [2:0] ecn,
                              input logic [63:0] eo, input logic en);
    vec_t v;
    v.name = nm; v.op = op; v.d = d; v.r = r;
    v.ec = ec; v.ecn = ecn; v.eo = eo; v.en = en;
    return v;
  endfunction

  function automatic vec_t mk_model(input string nm, input logic [10:0] op,
                                    input logic [8:0] d, input logic r);
    model_t m;
    m = ref_model(op, d, r);
    return mk(nm, op, d, r, m.c, m.cn, ref_offset(d), d[8]);
  endfunction

  vec_t tbl[$];

  initial begin
    rst = 1'b1; opcode = 11'b11101011000; dAddr9 = 9'd0;
    model_ill = 1'b0;
    repeat (2) @(posedge clk);

    tbl.push_back(mk("rst_subs", 11'b11101011000, 9'h000, 1, 15'b0000_0000_0000_000, 3'b000, 64'd0,   0));
    tbl.push_back(mk("adds",     11'b10101011000, 9'h005, 0, 15'b0000_1001_0000_011, 3'b010, 64'd5,   0));
    tbl.push_back(mk("subs",     11'b11101011000, 9'h000, 0, 15'b0000_1001_0000_011, 3'b011, 64'd0,   0));
    tbl.push_back(mk("addi",     11'b10010001001, 9'h000, 0, 15'b0000_0111_0000_010, 3'b010, 64'd0,   0));
    tbl.push_back(mk("ldur_neg", 11'b11111000010, 9'h1F8, 0, 15'b0000_0101_1010_010, 3'b011, 64'd8,   1));
    tbl.push_back(mk("stur_255", 11'b11111000000, 9'h0FF, 0, 15'b0000_0100_0100_010, 3'b010, 64'd255, 0));
    tbl.push_back(mk("ldur_min", 11'b11111000010, 9'h100, 0, 15'b0000_0101_1010_010, 3'b011, 64'd256, 1));
    tbl.push_back(mk("lsl",      11'b11010011011, 9'h1FF, 0, 15'b0000_0001_0001_000, 3'b000, 64'd1,   1));
    tbl.push_back(mk("lsr",      11'b11010011010, 9'h001, 0, 15'b0000_0001_0001_100, 3'b000, 64'd1,   0));
    tbl.push_back(mk("b",        11'b00010110101, 9'h000, 0, 15'b1100_0000_0000_000, 3'b000, 64'd0,   0));
    tbl.push_back(mk("bl",       11'b10010111010, 9'h000, 0, 15'b1101_0001_0000_000, 3'b000, 64'd0,   0));
    tbl.push_back(mk("br",       11'b11010110000, 9'h000, 0, 15'b1110_0000_0000_000, 3'b000, 64'd0,   0));
    tbl.push_back(mk("cbz",      11'b10110100110, 9'h000, 0, 15'b0100_0000_0000_010, 3'b000, 64'd0,   0));
    tbl.push_back(mk("bcond",    11'b01010100011, 9'h000, 0, 15'b0100_0000_0000_000, 3'b000, 64'd0,   0));
    tbl.push_back(mk("rst_ldur", 11'b11111000010, 9'h1F8, 1, 15'b0000_0000_0000_000, 3'b000, 64'd8,   1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Sticky illegal flag: set by an unknown opcode, survives valid ones, cleared by rst.
    step(mk("nop", 11'b00000000000, 9'h000, 0, 15'b0, 3'b000, 64'd0, 0));
    chk("ill_model_set", 64'(model_ill), 64'd1);
    step(mk_model("after_nop_adds", 11'b10101011000, 9'h000, 0));
    chk("ill_set", 64'(illegal), 64'd1);
    step(mk_model("after_nop_b", 11'b00010100000, 9'h000, 0));
    chk("ill_held", 64'(illegal), 64'd1);
    step(mk_model("ill_rst", 11'b00000000000, 9'h000, 1));
    step(mk_model("after_rst", 11'b11101011000, 9'h000, 0));
    chk("ill_cleared", 64'(illegal), 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [10:0] op;
      logic [10:0] rnd;
      logic [8:0]  d;
      logic        r;
      rnd = 11'($urandom);
      d   = 9'($urandom);
      r   = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 13))
        0:  op = 11'b10101011000;
        1:  op = 11'b11101011000;
        2:  op = 11'b11111000010;
        3:  op = 11'b11111000000;
        4:  op = 11'b11010011011;
        5:  op = 11'b11010011010;
        6:  op = 11'b11010110000;
        7:  op = {10'b1001000100, rnd[0]};
        8:  op = {8'b10110100, rnd[2:0]};
        9:  op = {8'b01010100, rnd[2:0]};
        10: op = {6'b000101, rnd[4:0]};
        11: op = {6'b100101, rnd[4:0]};
        default: op = rnd;
      endcase
      step(mk_model("rand", op, d, r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
